// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// mem_initiator : burst read/write initiator driving a single-port memory.
// Optional build macro MEM_WR_VERIFY_EN adds a read-back verify after each write.
// Rev 1.0
// ============================================================================
module mem_initiator #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_DRAIN = 3'd2,
        WR_BEAT  = 3'd3,
        DONE     = 3'd4
`ifdef MEM_WR_VERIFY_EN
        ,
        VFY_RD   = 3'd5,
        VFY_CMP  = 3'd6
`endif
    } state_t;

    state_t              state_q;
    logic [2:0]          len_q;
    logic [2:0]          idx_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                last_q;
    logic                drain_q;
    logic                rpipe_q;
    logic                req_ready_q;
    logic                wr_ready_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                done_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
`ifdef MEM_WR_VERIFY_EN
    logic                cmp_q;
    logic                err_q;
`endif

    logic                accept_d;
    logic                wbeat_d;
    logic [ADDR_W-1:0]   addr_inc_d;

    always_comb begin
        accept_d   = req_valid && req_ready_q;
        wbeat_d    = wr_valid && wr_ready_q;
        addr_inc_d = addr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            last_q      <= 1'b0;
            drain_q     <= 1'b0;
            rpipe_q     <= 1'b0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MEM_WR_VERIFY_EN
            cmp_q       <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b0;
            // Read data returns one cycle after the strobe and is registered once more.
            rpipe_q     <= mem_read_q && (state_q == RD_ISSUE);
            rd_valid_q  <= rpipe_q;
            if (rpipe_q) begin
                rd_data_q <= mem_rdata;
            end

            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        req_ready_q <= 1'b0;
                        len_q       <= req_len;
                        idx_q       <= '0;
                        last_q      <= 1'b0;
`ifdef MEM_WR_VERIFY_EN
                        err_q       <= 1'b0;
`endif
                        if (req_write) begin
                            state_q    <= WR_BEAT;
                            wr_ready_q <= 1'b1;
                            addr_q     <= req_addr;
                        end else begin
                            state_q    <= RD_ISSUE;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= req_addr;
                            addr_q     <= req_addr + ADDR_W'(1);
                        end
                    end
                end
                RD_ISSUE: begin
                    if (idx_q == len_q) begin
                        state_q <= RD_DRAIN;
                        drain_q <= 1'b0;
                    end else begin
                        mem_read_q <= 1'b1;
                        mem_addr_q <= addr_q;
                        addr_q     <= addr_inc_d;
                        idx_q      <= idx_q + 3'd1;
                    end
                end
                RD_DRAIN: begin
                    if (!drain_q) begin
                        drain_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                WR_BEAT: begin
                    if (wbeat_d) begin
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= wr_data;
                        addr_q      <= addr_inc_d;
                        if (idx_q == len_q) begin
                            wr_ready_q <= 1'b0;
                            last_q     <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
`ifdef MEM_WR_VERIFY_EN
                        wr_ready_q <= 1'b0;
                        state_q    <= VFY_RD;
`endif
                    end else if (last_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
`ifdef MEM_WR_VERIFY_EN
                VFY_RD: begin
                    mem_read_q <= 1'b1;
                    cmp_q      <= 1'b0;
                    state_q    <= VFY_CMP;
                end
                VFY_CMP: begin
                    if (!cmp_q) begin
                        cmp_q <= 1'b1;
                    end else begin
                        if (mem_rdata != mem_wdata_q) begin
                            err_q <= 1'b1;
                        end
                        if (last_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= WR_BEAT;
                            wr_ready_q <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef MEM_WR_VERIFY_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
// tb_mem_initiator : directed self-checking bench with a 32-word memory model.
// Rev 1.0
// ============================================================================
module tb_mem_initiator;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [4:0] req_addr;
    logic [2:0] req_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       err;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic       mem_init;
    logic       corrupt;
    logic [7:0] mem    [32];
    logic [7:0] shadow [32];

    int errors = 0;
    int checks = 0;
    int n_wr   = 0;
    int n_rd   = 0;
    int n_done = 0;
    int n_both = 0;

    mem_initiator #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: registered read data, optional corruption of read-back.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 7 + 3);
            mem_rdata <= 8'h00;
        end else begin
            if (mem_write) mem[mem_addr] <= mem_wdata;
            if (mem_read) mem_rdata <= corrupt ? 8'hFF : mem[mem_addr];
        end
        if (mem_write) n_wr <= n_wr + 1;
        if (mem_read) n_rd <= n_rd + 1;
        if (done) n_done <= n_done + 1;
        if (mem_read && mem_write) n_both <= n_both + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [2:0] len,
                            input logic [7:0] d [8], input int gap);
        logic [4:0] a;
        int k;
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len;
        if (req_ready !== 1'b1) begin $display("FAIL wr_req_ready got=%b exp=1", req_ready); errors++; end
        checks++;
        tick;
        req_valid = 1'b0;
        if (req_ready !== 1'b0) begin $display("FAIL wr_req_ready_busy got=%b exp=0", req_ready); errors++; end
        checks++;
        for (int i = 0; i <= int'(len); i++) begin
            k = 0;
            while (wr_ready !== 1'b1 && k < 8) begin tick; k++; end
            if (wr_ready !== 1'b1) begin
                $display("FAIL wr_ready_timeout beat=%0d got=%b exp=1", i, wr_ready); errors++; checks++;
                return;
            end
            wr_valid = 1'b1; wr_data = d[i];
            tick;
            wr_valid = 1'b0;
            a = addr + 5'(i);
            shadow[a] = d[i];
            if (mem_write !== 1'b1 || mem_addr !== a || mem_wdata !== d[i] || mem_read !== 1'b0) begin
                $display("FAIL wr_beat%0d got we=%b a=%0d d=%h rd=%b exp we=1 a=%0d d=%h rd=0",
                         i, mem_write, mem_addr, mem_wdata, mem_read, a, d[i]);
                errors++;
            end
            checks++;
`ifndef MEM_WR_VERIFY_EN
            if (gap == 0 && i < int'(len)) begin
                if (wr_ready !== 1'b1) begin $display("FAIL wr_b2b_ready got=%b exp=1", wr_ready); errors++; end
                checks++;
            end
`endif
            if (i < int'(len)) begin
                for (int g = 0; g < gap; g++) begin
                    tick;
                    if (mem_write !== 1'b0) begin $display("FAIL wr_gap%0d got=%b exp=0", g, mem_write); errors++; end
                    checks++;
                end
            end
        end
        k = 0;
        while (done !== 1'b1 && k < 8) begin tick; k++; end
        if (done !== 1'b1) begin $display("FAIL wr_done got=%b exp=1", done); errors++; end
        checks++;
`ifndef MEM_WR_VERIFY_EN
        if (k !== 1) begin $display("FAIL wr_done_latency got=%0d exp=1", k); errors++; end
        checks++;
`endif
        tick;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL wr_end got done=%b ready=%b exp done=0 ready=1", done, req_ready); errors++;
        end
        checks++;
    endtask

    task automatic do_read(input logic [4:0] addr, input logic [2:0] len);
        int   L;
        logic [4:0] a;
        L = int'(len) + 1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
        tick;
        req_valid = 1'b0;
        if (err !== 1'b0) begin $display("FAIL rd_err_cleared got=%b exp=0", err); errors++; end
        checks++;
        for (int k = 1; k <= L + 3; k++) begin
            if (k > 1) tick;
            if (mem_read !== (k <= L)) begin
                $display("FAIL rd_strobe k=%0d got=%b exp=%b", k, mem_read, (k <= L)); errors++;
            end
            checks++;
            if (k <= L) begin
                a = addr + 5'(k - 1);
                if (mem_addr !== a) begin $display("FAIL rd_addr k=%0d got=%0d exp=%0d", k, mem_addr, a); errors++; end
                checks++;
            end
            if (rd_valid !== (k >= 3 && k <= L + 2)) begin
                $display("FAIL rd_valid k=%0d got=%b exp=%b", k, rd_valid, (k >= 3 && k <= L + 2)); errors++;
            end
            checks++;
            if (k >= 3 && k <= L + 2) begin
                a = addr + 5'(k - 3);
                if (rd_data !== shadow[a]) begin
                    $display("FAIL rd_data k=%0d got=%h exp=%h", k, rd_data, shadow[a]); errors++;
                end
                checks++;
            end
            if (done !== (k == L + 2)) begin $display("FAIL rd_done k=%0d got=%b exp=%b", k, done, (k == L + 2)); errors++; end
            checks++;
            if (k == L + 3) begin
                if (req_ready !== 1'b1) begin $display("FAIL rd_ready_after got=%b exp=1", req_ready); errors++; end
                checks++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_init = 1'b1; corrupt = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0;
        for (int i = 0; i < 32; i++) shadow[i] = 8'(i * 7 + 3);
        repeat (3) tick;
        rst = 1'b0; mem_init = 1'b0;
        tick;
        if (req_ready !== 1'b1) begin $display("FAIL rst_req_ready got=%b exp=1", req_ready); errors++; end
        checks++;
        if (wr_ready !== 1'b0) begin $display("FAIL rst_wr_ready got=%b exp=0", wr_ready); errors++; end
        checks++;
        if (rd_valid !== 1'b0) begin $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); errors++; end
        checks++;
        if (done !== 1'b0) begin $display("FAIL rst_done got=%b exp=0", done); errors++; end
        checks++;
        if (err !== 1'b0) begin $display("FAIL rst_err got=%b exp=0", err); errors++; end
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            $display("FAIL rst_strobes got rd=%b wr=%b exp 0 0", mem_read, mem_write); errors++;
        end
        checks++;
        if (mem_addr !== 5'd0 || mem_wdata !== 8'h00 || rd_data !== 8'h00) begin
            $display("FAIL rst_data got a=%0d wd=%h rd=%h exp 0 00 00", mem_addr, mem_wdata, rd_data); errors++;
        end
        checks++;
    endtask

    task automatic test_write_burst;
        logic [7:0] d [8];
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        do_write(5'd4, 3'd3, d, 0);
        if (err !== 1'b0) begin $display("FAIL wr_err got=%b exp=0", err); errors++; end
        checks++;
    endtask

    task automatic test_read_burst;
        do_read(5'd4, 3'd3);
    endtask

    task automatic test_wrap;
        do_read(5'd30, 3'd3);
    endtask

    task automatic test_write_gaps;
        logic [7:0] d [8];
        int n0;
        d = '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        n0 = n_wr;
        do_write(5'd10, 3'd1, d, 2);
        if (n_wr - n0 !== 2) begin $display("FAIL gap_write_count got=%0d exp=2", n_wr - n0); errors++; end
        checks++;
        do_read(5'd10, 3'd1);
    endtask

    task automatic test_verify;
        logic [7:0] d [8];
        d = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        corrupt = 1'b1;
        do_write(5'd20, 3'd0, d, 0);
        corrupt = 1'b0;
`ifdef MEM_WR_VERIFY_EN
        if (err !== 1'b1) begin $display("FAIL vfy_err_set got=%b exp=1", err); errors++; end
`else
        if (err !== 1'b0) begin $display("FAIL err_tied got=%b exp=0", err); errors++; end
`endif
        checks++;
        do_read(5'd20, 3'd0);
    endtask

    task automatic test_reset_mid;
        int nr0, nd0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd0; req_len = 3'd7;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        if (mem_read !== 1'b1 || mem_addr !== 5'd2) begin
            $display("FAIL mid_third_issue got rd=%b a=%0d exp rd=1 a=2", mem_read, mem_addr); errors++;
        end
        checks++;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        nr0 = n_rd; nd0 = n_done;
        if (mem_read !== 1'b0) begin $display("FAIL mid_read_stop got=%b exp=0", mem_read); errors++; end
        checks++;
        tick;
        if (req_ready !== 1'b1) begin $display("FAIL mid_ready got=%b exp=1", req_ready); errors++; end
        checks++;
        repeat (8) tick;
        if (n_rd !== nr0 || n_done !== nd0) begin
            $display("FAIL mid_no_activity got reads=%0d dones=%0d exp 0 0", n_rd - nr0, n_done - nd0); errors++;
        end
        checks++;
        if (rd_valid !== 1'b0) begin $display("FAIL mid_rd_valid got=%b exp=0", rd_valid); errors++; end
        checks++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_write_burst;
        test_read_burst;
        test_wrap;
        test_write_gaps;
        test_verify;
        test_reset_mid;
        if (n_both !== 0) begin $display("FAIL strobe_overlap got=%0d exp=0", n_both); errors++; end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
